sdram_wb_bridge: RTL and testbench
==================================

Name: sdram_wb_bridge

Overview:
- Parametrised Wishbone-slave to SDRAM-controller bridge; sits between topboard's SDRAM port and sdram_top.
- Generalises the board-level glue into one registered block: controller reset release delay, latched byte masks/DQM, request/ack handshake with configurable ack delay, full-word read mode, abort draining and a timeout error.

Parameters:
- AW, 21, Wishbone word-address width (adr[AW:1]).
- DW, 16, data width; multiple of 8.
- SW, DW/8, byte-select width.
- RST_DELAY, 3, clocks after reset release before ctl_rst_n rises (1..15).
- ACK_DELAY, 2, clocks from controller ack to wb_ack (1..7).
- RD_FULLWORD, 1, 1 = reads force all DQM low; 0 = reads use wb_sel.
- TIMEOUT, 1023, max clocks waiting for controller ack; 0 = disabled.

Ports:
- clk_p  in  1  bus clock, rising edge.
- sdram_reset  in  1  asynchronous, active-high reset.
- wb_stb  in  1  transaction strobe, held until wb_ack or wb_err.
- wb_we  in  1  1 = write.
- wb_sel  in  SW  byte enables, active high.
- wb_adr  in  AW  word address.
- wb_dat_i  in  DW  write data.
- wb_dat_o  out  DW  read data.
- wb_ack  out  1  transaction done.
- wb_err  out  1  timeout.
- ready  out  1  controller initialised, pass-through of registered ctl_init_done.
- ctl_rst_n  out  1  controller reset, active low.
- ctl_wr_req  out  1  write request.
- ctl_rd_req  out  1  read request.
- ctl_wr_ack  in  1  controller write ack.
- ctl_rd_ack  in  1  controller read ack.
- ctl_addr  out  AW+1  {1'b0, latched address}.
- ctl_be  out  SW  latched byte enables.
- ctl_data_in  out  DW  latched write data.
- ctl_data_out  in  DW  read data from controller.
- ctl_init_done  in  1  controller init complete.
- dqm  out  SW  SDRAM data masks, active high (1 = masked).

Behaviour:
- Reset is asynchronous and active-high; all outputs are 0 during reset except dqm, which is all-ones. ctl_rst_n=0, FSM=IDLE.
- Reset release: a counter increments on each clk_p edge after sdram_reset falls. ctl_rst_n rises on the (RST_DELAY+1)th edge and stays high until the next reset.
- ready is ctl_init_done registered once. While ready=0, wb_stb is ignored: no request, no ack.
- FSM states: IDLE, REQ, WAIT, DELAY, DONE, DRAIN.
- IDLE: when wb_stb && ready, latch adr, we, sel and dat_i.
  - dqm <= ~sel for writes.
  - dqm <= 0 for reads if RD_FULLWORD=1, else ~sel.
  - Go to REQ.
- REQ: assert ctl_wr_req or ctl_rd_req (one-hot with we) for exactly one cycle, then go to WAIT.
- WAIT: increment the timeout counter.
  - On the matching ack (ctl_wr_ack for writes, ctl_rd_ack for reads), capture ctl_data_out into wb_dat_o (reads only), then go to DELAY with the delay counter = 1.
  - The non-matching ack is ignored.
- DELAY: count to ACK_DELAY, then assert wb_ack and go to DONE.
  - Total latency is ACK_DELAY clocks from the sampled controller ack to wb_ack high.
- DONE: hold wb_ack while wb_stb=1. When wb_stb=0, drop wb_ack in the same cycle (combinational AND with wb_stb) and go to IDLE.
  - A back-to-back wb_stb needs at least one low cycle.
- Abort: if wb_stb falls in REQ, WAIT or DELAY, go to DRAIN.
  - DRAIN waits for the outstanding controller ack (or timeout), never asserts wb_ack, then goes to IDLE.
  - A new stb during DRAIN waits.
- Timeout (TIMEOUT>0): when the counter reaches TIMEOUT in WAIT, assert wb_err while wb_stb=1 and go to DONE with the ack path suppressed. A late controller ack is discarded.
- wb_dat_o holds its value until the next read capture.
- dqm holds between transactions.
- Reset mid-transaction: everything clears immediately and ctl_rst_n drops. Requests restart only after ready reasserts.

Test Plan:
- Reset release: RST_DELAY=3, deassert sdram_reset → ctl_rst_n rises on the 4th edge. wb_stb with ctl_init_done=0 → no ctl request, no ack for 50 cycles.
- Write with byte mask: wb_we=1, sel=2'b10, adr=21'h0ABCD, dat=16'h1234 → ctl_wr_req for one cycle, ctl_addr=22'h00ABCD, dqm=2'b01; ctl_wr_ack at cycle t → wb_ack at t+2.
- Read: RD_FULLWORD=1, sel=2'b01 → dqm=2'b00; ctl_data_out=16'hBEEF on ctl_rd_ack → wb_dat_o=16'hBEEF with wb_ack. Repeat with RD_FULLWORD=0 → dqm=2'b10.
- Abort: drop wb_stb in WAIT; ctl_rd_ack arrives 5 cycles later → no wb_ack. The next stb issues ctl_rd_req only after that ack.
- Timeout: TIMEOUT=8, never ack → wb_err on the 8th WAIT cycle, wb_ack stays 0. A late ack is ignored and the next transaction completes normally.
- Async reset in DELAY → wb_ack=0, dqm=all-ones, ctl_rst_n=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge: registered Wishbone slave front-end for the SDRAM controller,
// handling controller reset release, DQM latching, delayed ack, abort drain and timeout.
module sdram_wb_bridge #(
    parameter int AW = 21,
    parameter int DW = 16,
    parameter int SW = DW / 8,
    parameter int RST_DELAY = 3,
    parameter int ACK_DELAY = 2,
    parameter bit RD_FULLWORD = 1'b1,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_p,
    input  logic          sdram_reset,
    input  logic          wb_stb,
    input  logic          wb_we,
    input  logic [SW-1:0] wb_sel,
    input  logic [AW-1:0] wb_adr,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack,
    output logic          wb_err,
    output logic          ready,
    output logic          ctl_rst_n,
    output logic          ctl_wr_req,
    output logic          ctl_rd_req,
    input  logic          ctl_wr_ack,
    input  logic          ctl_rd_ack,
    output logic [AW:0]   ctl_addr,
    output logic [SW-1:0] ctl_be,
    output logic [DW-1:0] ctl_data_in,
    input  logic [DW-1:0] ctl_data_out,
    input  logic          ctl_init_done,
    output logic [SW-1:0] dqm
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DELAY, DONE, DRAIN} state_t;

    state_t        st, st_nx;
    logic [3:0]    rst_cnt;
    logic [2:0]    dly_cnt;
    logic [TW-1:0] to_cnt;
    logic          we_r, err_r, pend;
    logic [AW-1:0] adr_r;
    logic          match, to_hit, delay_hit;

    assign match = we_r ? ctl_wr_ack : ctl_rd_ack;
    // to_hit marks the TIMEOUT-th cycle spent waiting for the controller
    assign to_hit = (TIMEOUT > 0) && (to_cnt >= TW'(TO_LAST));
    assign delay_hit = dly_cnt == 3'(ACK_DELAY);

    assign ctl_addr = {1'b0, adr_r};
    assign ctl_wr_req = (st == REQ) && we_r;
    assign ctl_rd_req = (st == REQ) && !we_r;
    assign wb_ack = wb_stb && !err_r && (st == DONE || (st == DELAY && delay_hit));
    assign wb_err = wb_stb && (st == DONE ? err_r : (st == WAIT && to_hit && !match));

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = (wb_stb && ready) ? REQ : IDLE;
            REQ:     st_nx = wb_stb ? WAIT : DRAIN;
            WAIT:    st_nx = !wb_stb ? DRAIN : match ? DELAY : to_hit ? DONE : WAIT;
            DELAY:   st_nx = !wb_stb ? DRAIN : delay_hit ? DONE : DELAY;
            DONE:    st_nx = wb_stb ? DONE : IDLE;
            DRAIN:   st_nx = (!pend || match || to_hit) ? IDLE : DRAIN;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_p or posedge sdram_reset) begin
        if (sdram_reset) begin
            st          <= IDLE;
            rst_cnt     <= '0;
            ctl_rst_n   <= 1'b0;
            ready       <= 1'b0;
            dly_cnt     <= 3'd1;
            to_cnt      <= '0;
            we_r        <= 1'b0;
            err_r       <= 1'b0;
            pend        <= 1'b0;
            adr_r       <= '0;
            ctl_be      <= '0;
            ctl_data_in <= '0;
            wb_dat_o    <= '0;
            dqm         <= '1;
        end else begin
            st    <= st_nx;
            ready <= ctl_init_done;
            if (!ctl_rst_n) begin
                rst_cnt   <= rst_cnt + 4'd1;
                ctl_rst_n <= rst_cnt == 4'(RST_DELAY);
            end
            if (st == IDLE && st_nx == REQ) begin
                we_r        <= wb_we;
                adr_r       <= wb_adr;
                ctl_be      <= wb_sel;
                ctl_data_in <= wb_dat_i;
                dqm         <= (wb_we || !RD_FULLWORD) ? ~wb_sel : '0;
            end
            // pend tracks a request the controller has not yet acknowledged
            pend    <= (st == REQ) || (pend && !match);
            to_cnt  <= (st == WAIT || st == DRAIN) ? to_cnt + TW'(1) : '0;
            dly_cnt <= (st == DELAY) ? dly_cnt + 3'd1 : 3'd1;
            err_r   <= (st_nx == DONE) && (st == DONE ? err_r : st == WAIT);
            if (st == WAIT && match && !we_r)
                wb_dat_o <= ctl_data_out;
        end
    end
endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb_sdram_wb_bridge: directed scoreboard bench; a second instance with
// RD_FULLWORD=0 shares the stimulus so both read-mask modes are observed.
module tb_sdram_wb_bridge;
    logic        clk_p = 1'b0;
    logic        sdram_reset, wb_stb, wb_we, ctl_wr_ack, ctl_rd_ack, ctl_init_done;
    logic [1:0]  wb_sel;
    logic [20:0] wb_adr;
    logic [15:0] wb_dat_i, ctl_data_out;
    logic [15:0] wb_dat_o, ctl_data_in, dat_o1, din1;
    logic        wb_ack, wb_err, ready, ctl_rst_n, ctl_wr_req, ctl_rd_req;
    logic        ack1, err1, ready1, rstn1, wrreq1, rdreq1;
    logic [21:0] ctl_addr, addr1;
    logic [1:0]  ctl_be, dqm, be1, dqm1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        saw;
    logic [15:0] last_rd;
    logic [15:0] exp_q[$];

    always #5 clk_p = ~clk_p;

    sdram_wb_bridge #(.TIMEOUT(8)) u_dut (
        .clk_p(clk_p), .sdram_reset(sdram_reset), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .wb_err(wb_err), .ready(ready), .ctl_rst_n(ctl_rst_n),
        .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req), .ctl_wr_ack(ctl_wr_ack),
        .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr), .ctl_be(ctl_be),
        .ctl_data_in(ctl_data_in), .ctl_data_out(ctl_data_out),
        .ctl_init_done(ctl_init_done), .dqm(dqm)
    );

    sdram_wb_bridge #(.RD_FULLWORD(1'b0), .TIMEOUT(8)) u_sel (
        .clk_p(clk_p), .sdram_reset(sdram_reset), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat_o1),
        .wb_ack(ack1), .wb_err(err1), .ready(ready1), .ctl_rst_n(rstn1),
        .ctl_wr_req(wrreq1), .ctl_rd_req(rdreq1), .ctl_wr_ack(ctl_wr_ack),
        .ctl_rd_ack(ctl_rd_ack), .ctl_addr(addr1), .ctl_be(be1),
        .ctl_data_in(din1), .ctl_data_out(ctl_data_out),
        .ctl_init_done(ctl_init_done), .dqm(dqm1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic we, input logic [1:0] sel, input logic [20:0] adr,
                       input logic [15:0] dat, input logic [15:0] rd);
        int n;
        if (!we) exp_q.push_back(rd);
        @(posedge clk_p); #1;
        wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
        n = 0;
        do begin @(negedge clk_p); n++; end while (!(ctl_wr_req || ctl_rd_req) && n < 20);
        chk("req_seen", 32'(n < 20), 1);
        chk("req_dir", {ctl_wr_req, ctl_rd_req}, {we, !we});
        chk("ctl_addr", ctl_addr, {1'b0, adr});
        chk("ctl_be", ctl_be, sel);
        if (we) chk("ctl_data_in", ctl_data_in, dat);
        chk("dqm_full", dqm, we ? 2'(~sel) : 2'b00);
        chk("dqm_sel", dqm1, 2'(~sel));
        @(negedge clk_p); chk("req_one", {ctl_wr_req, ctl_rd_req}, 0);
        @(posedge clk_p); #1;
        ctl_wr_ack = we; ctl_rd_ack = !we; ctl_data_out = rd;
        @(negedge clk_p); chk("ack_t0", wb_ack, 0);
        @(posedge clk_p); #1;
        ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_data_out = 16'h0;
        @(negedge clk_p); chk("ack_t1", wb_ack, 0);
        @(negedge clk_p); chk("ack_t2", wb_ack, 1);
        if (!we) begin
            last_rd = exp_q.pop_front();
            chk("rdata", wb_dat_o, last_rd);
        end
        @(negedge clk_p); chk("ack_hold", wb_ack, 1);
        wb_stb = 1'b0;
        #1 chk("ack_drop", wb_ack, 0);
        @(posedge clk_p); #1;
        chk("dqm_hold", dqm, we ? 2'(~sel) : 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sdram_reset = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 2'b00; wb_adr = '0;
        wb_dat_i = '0; ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_data_out = '0;
        ctl_init_done = 1'b0; last_rd = '0;
        repeat (3) @(posedge clk_p);
        @(negedge clk_p);
        chk("rst_dqm", dqm, 2'b11);
        chk("rst_rstn", ctl_rst_n, 0);
        chk("rst_outs", {wb_ack, wb_err, ready, ctl_wr_req, ctl_rd_req}, 0);
        chk("rst_dato", wb_dat_o, 0);
        sdram_reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_p); #1 chk("rstn_edge", ctl_rst_n, 32'(k == 4));
        end

        // strobe while the controller is not initialised must be ignored
        wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11;
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk_p);
            saw |= ctl_wr_req | ctl_rd_req | wb_ack | wb_err;
        end
        chk("no_req_unready", saw, 0);
        wb_stb = 1'b0; ctl_init_done = 1'b1;
        repeat (2) @(negedge clk_p);
        chk("ready", ready, 1);

        run(1'b1, 2'b10, 21'h0ABCD, 16'h1234, 16'h0);
        run(1'b0, 2'b01, 21'h00123, 16'h0, 16'hBEEF);

        // abort in WAIT, controller ack 5 cycles after the drop
        @(posedge clk_p); #1;
        wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h1F000;
        @(negedge clk_p); @(negedge clk_p);
        chk("abort_req", ctl_rd_req, 1);
        @(negedge clk_p);
        wb_stb = 1'b0;
        saw = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_p);
            saw |= wb_ack | ctl_rd_req | ctl_wr_req;
            if (i == 1) wb_stb = 1'b1;
        end
        @(negedge clk_p);
        saw |= wb_ack | ctl_rd_req | ctl_wr_req;
        ctl_rd_ack = 1'b1; ctl_data_out = 16'h5A5A;
        @(negedge clk_p);
        saw |= wb_ack | ctl_rd_req | ctl_wr_req;
        ctl_rd_ack = 1'b0; ctl_data_out = 16'h0;
        chk("abort_quiet", saw, 0);
        run(1'b0, 2'b11, 21'h1F000, 16'h0, 16'hC0DE);

        // timeout: never ack
        @(posedge clk_p); #1;
        wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b01; wb_adr = 21'h00777;
        @(negedge clk_p); @(negedge clk_p);
        chk("to_req", ctl_rd_req, 1);
        saw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_p);
            saw |= wb_ack;
            chk("to_err", wb_err, 32'(k == 8));
        end
        @(negedge clk_p);
        saw |= wb_ack;
        chk("to_done_err", wb_err, 1);
        ctl_rd_ack = 1'b1; ctl_data_out = 16'h9999;
        @(negedge clk_p);
        saw |= wb_ack;
        chk("to_late_err", wb_err, 1);
        ctl_rd_ack = 1'b0; ctl_data_out = 16'h0;
        wb_stb = 1'b0;
        #1 chk("to_err_drop", wb_err, 0);
        chk("to_no_ack", saw, 0);
        chk("to_dat_hold", wb_dat_o, last_rd);
        run(1'b0, 2'b10, 21'h00555, 16'h0, 16'h1357);

        // asynchronous reset while DELAY is presenting wb_ack
        @(posedge clk_p); #1;
        wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b11; wb_adr = 21'h00002; wb_dat_i = 16'hAAAA;
        @(negedge clk_p); @(negedge clk_p);
        chk("ar_req", ctl_wr_req, 1);
        @(negedge clk_p);
        @(posedge clk_p); #1 ctl_wr_ack = 1'b1;
        @(posedge clk_p); #1 ctl_wr_ack = 1'b0;
        @(posedge clk_p); #2;
        chk("ar_pre_ack", wb_ack, 1);
        sdram_reset = 1'b1;
        #1;
        chk("ar_ack", wb_ack, 0);
        chk("ar_dqm", dqm, 2'b11);
        chk("ar_rstn", ctl_rst_n, 0);
        wb_stb = 1'b0;
        repeat (2) @(posedge clk_p);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
